// File: rtl/detail_extract_pkg.sv
// Shared constants and the per-pixel detail clamp used by detail_extract.
package detail_extract_pkg;

  localparam int unsigned PIX_W               = 8;
  localparam int unsigned CLAMP_W             = 10;
  localparam int unsigned DEF_OFFSET          = 128;
  localparam int unsigned DEF_PIXELS_PER_BEAT = 16;
  localparam int unsigned DEF_IMAGE_DIM       = 512;
  localparam int unsigned COUNTER_MAX         = DEF_IMAGE_DIM / DEF_PIXELS_PER_BEAT;

  // orig - blur + off in signed 10-bit, saturated to 0..255
  function automatic logic [PIX_W-1:0] clamp_detail(input logic [PIX_W-1:0] orig,
                                                    input logic [PIX_W-1:0] blur,
                                                    input logic [PIX_W-1:0] off);
    logic signed [CLAMP_W-1:0] d;
    d = $signed(CLAMP_W'(orig)) - $signed(CLAMP_W'(blur)) + $signed(CLAMP_W'(off));
    if (d[CLAMP_W-1]) begin
      return '0;
    end else if (d[CLAMP_W-2:PIX_W] != '0) begin
      return '1;
    end else begin
      return d[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/detail_extract_beat_delay.sv
// Circular beat delay line; read returns the entry about to be overwritten.
module beat_delay #(
  parameter int unsigned DEPTH = 33,
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

  // Storage is left unreset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  assign dout_c = mem[ptr];

endmodule

// File: rtl/detail_extract.sv
// Detail layer: delayed original minus blurred beat, offset and clamped per lane,
// tagged with output column/row and end-of-frame.
module detail_extract
  import detail_extract_pkg::*;
#(
  parameter int unsigned PIXELS_PER_BEAT = DEF_PIXELS_PER_BEAT,
  parameter int unsigned IMAGE_DIM       = DEF_IMAGE_DIM,
  parameter int unsigned DATA_WIDTH      = PIX_W * PIXELS_PER_BEAT,
  parameter int unsigned LAT_BEATS       = IMAGE_DIM / PIXELS_PER_BEAT + 1,
  parameter int unsigned OFFSET          = DEF_OFFSET
) (
  input  logic                                          clk,
  input  logic                                          aresetn,
  input  logic                                          stall,
  input  logic [DATA_WIDTH-1:0]                         orig_frame,
  input  logic [DATA_WIDTH-1:0]                         blur_frame,
  output logic [DATA_WIDTH-1:0]                         detail_frame,
  output logic                                          detail_valid,
  output logic [$clog2(IMAGE_DIM/PIXELS_PER_BEAT)-1:0]  out_col,
  output logic [$clog2(IMAGE_DIM)-1:0]                  out_row,
  output logic                                          frame_last
);

  localparam int unsigned COLS  = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(IMAGE_DIM);
  localparam int unsigned CNT_W = $clog2(LAT_BEATS + 1);

  logic                  accept_c;
  logic [DATA_WIDTH-1:0] orig_d_c;
  logic [DATA_WIDTH-1:0] detail_c;
  logic [CNT_W-1:0]      warm_cnt;
  logic                  warm_done_c;
  logic [COL_W-1:0]      col_nxt_c;
  logic [ROW_W-1:0]      row_nxt_c;
  logic                  last_nxt_c;

  assign accept_c    = aresetn & ~stall;
  assign warm_done_c = (warm_cnt == CNT_W'(LAT_BEATS));

  beat_delay #(
    .DEPTH (LAT_BEATS),
    .WIDTH (DATA_WIDTH)
  ) u_beat_delay (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (accept_c),
    .din     (orig_frame),
    .dout_c  (orig_d_c)
  );

  for (genvar k = 0; k < PIXELS_PER_BEAT; k++) begin : g_lane
    assign detail_c[PIX_W*k +: PIX_W] = clamp_detail(orig_d_c[PIX_W*k +: PIX_W],
                                                     blur_frame[PIX_W*k +: PIX_W],
                                                     PIX_W'(OFFSET));
  end

  // Position of the next result; the first valid result sits at (0,0)
  always_comb begin
    col_nxt_c = out_col;
    row_nxt_c = out_row;
    if (detail_valid) begin
      if (out_col == COL_W'(COLS - 1)) begin
        col_nxt_c = '0;
        row_nxt_c = (out_row == ROW_W'(IMAGE_DIM - 1)) ? '0 : out_row + ROW_W'(1);
      end else begin
        col_nxt_c = out_col + COL_W'(1);
      end
    end
    last_nxt_c = (col_nxt_c == COL_W'(COLS - 1)) && (row_nxt_c == ROW_W'(IMAGE_DIM - 1));
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      detail_frame <= '0;
      detail_valid <= 1'b0;
      out_col      <= '0;
      out_row      <= '0;
      frame_last   <= 1'b0;
      warm_cnt     <= '0;
    end else if (!stall) begin
      if (warm_done_c) begin
        detail_frame <= detail_c;
        detail_valid <= 1'b1;
        out_col      <= col_nxt_c;
        out_row      <= row_nxt_c;
        frame_last   <= last_nxt_c;
      end else begin
        detail_frame <= '0;
        detail_valid <= 1'b0;
        warm_cnt     <= warm_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_detail_extract.sv
// Randomized self-checking bench for detail_extract against a queue-based reference model.
module tb_detail_extract;

  localparam int DW   = 128;
  localparam int NL   = 16;
  localparam int DIM  = 512;
  localparam int COLS = 32;
  localparam int LAT  = 33;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          stall = 1'b1;
  logic [DW-1:0] orig_frame = '0;
  logic [DW-1:0] blur_frame = '0;
  logic [DW-1:0] detail_frame;
  logic          detail_valid;
  logic [4:0]    out_col;
  logic [8:0]    out_row;
  logic          frame_last;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] hist [$];
  int            vcnt = 0;
  logic [DW-1:0] exp_frame = '0;
  logic          exp_valid = 1'b0;
  logic [4:0]    exp_col = '0;
  logic [8:0]    exp_row = '0;
  logic          exp_last = 1'b0;

  detail_extract dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .stall        (stall),
    .orig_frame   (orig_frame),
    .blur_frame   (blur_frame),
    .detail_frame (detail_frame),
    .detail_valid (detail_valid),
    .out_col      (out_col),
    .out_row      (out_row),
    .frame_last   (frame_last)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] model_detail(input logic [DW-1:0] od, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int d;
    for (int k = 0; k < NL; k++) begin
      d = int'(od[8*k +: 8]) - int'(b[8*k +: 8]) + 128;
      if (d < 0) d = 0;
      if (d > 255) d = 255;
      r[8*k +: 8] = 8'(d);
    end
    return r;
  endfunction

  // Drive one clock and advance the model by what that edge should do
  task automatic drive(input logic rn, input logic st, input logic [DW-1:0] o, input logic [DW-1:0] b);
    logic [DW-1:0] od;
    aresetn = rn; stall = st; orig_frame = o; blur_frame = b;
    @(posedge clk); #1;
    if (!rn) begin
      hist.delete();
      vcnt = 0;
      exp_frame = '0; exp_valid = 1'b0; exp_col = '0; exp_row = '0; exp_last = 1'b0;
    end else if (!st) begin
      if (hist.size() == LAT) begin
        od = hist.pop_front();
        exp_frame = model_detail(od, b);
        exp_valid = 1'b1;
        exp_col   = 5'(vcnt % COLS);
        exp_row   = 9'((vcnt / COLS) % DIM);
        exp_last  = (vcnt % COLS == COLS - 1) && ((vcnt / COLS) % DIM == DIM - 1);
        vcnt++;
      end else begin
        exp_frame = '0;
        exp_valid = 1'b0;
      end
      hist.push_back(o);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'(i % 2), rnd_beat(), rnd_beat());
      total++;
      if ({detail_frame, detail_valid, out_col, out_row, frame_last} !== {DW'(0), 1'b0, 5'd0, 9'd0, 1'b0}) begin
        bad++;
        $display("FAIL reset: got %h required %h", {detail_frame, detail_valid, out_col, out_row, frame_last}, 144'h0);
      end
    end
  endtask

  task automatic test_constant();
    logic [DW-1:0] c100;
    logic [DW-1:0] c128;
    logic [DW-1:0] want;
    c100 = {NL{8'd100}};
    c128 = {NL{8'd128}};
    for (int n = 1; n <= LAT + 8; n++) begin
      drive(1'b1, 1'b0, c100, c100);
      want = (n > LAT) ? c128 : '0;
      total++;
      if (detail_valid !== (n > LAT) || detail_frame !== want) begin
        bad++;
        $display("FAIL constant beat %0d: got v=%0b %h required v=%0b %h", n, detail_valid, detail_frame, n > LAT, want);
      end
    end
  endtask

  task automatic test_clamp();
    logic [DW-1:0] o;
    logic [DW-1:0] b;
    o = rnd_beat();
    o[7:0] = 8'd255; o[15:8] = 8'd0; o[23:16] = 8'd10;
    drive(1'b1, 1'b0, o, rnd_beat());
    for (int i = 0; i < LAT - 1; i++) drive(1'b1, 1'b0, rnd_beat(), rnd_beat());
    b = rnd_beat();
    b[7:0] = 8'd0; b[15:8] = 8'd200; b[23:16] = 8'd5;
    drive(1'b1, 1'b0, rnd_beat(), b);
    total++;
    if (detail_frame[23:0] !== {8'd133, 8'd0, 8'd255} || detail_valid !== 1'b1) begin
      bad++;
      $display("FAIL clamp lanes: got %h required %h", detail_frame[23:0], {8'd133, 8'd0, 8'd255});
    end
    total++;
    if (detail_frame !== exp_frame) begin
      bad++;
      $display("FAIL clamp model: got %h required %h", detail_frame, exp_frame);
    end
  endtask

  task automatic test_stall_hold();
    logic [143:0] snap;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, rnd_beat(), rnd_beat());
    snap = {detail_frame, detail_valid, out_col, out_row, frame_last};
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, rnd_beat(), rnd_beat());
      total++;
      if ({detail_frame, detail_valid, out_col, out_row, frame_last} !== snap) begin
        bad++;
        $display("FAIL stall_hold cycle %0d: got %h required %h", i, {detail_frame, detail_valid, out_col, out_row, frame_last}, snap);
      end
    end
    drive(1'b1, 1'b0, rnd_beat(), rnd_beat());
    total++;
    if ({detail_frame, detail_valid, out_col, out_row, frame_last} !== {exp_frame, exp_valid, exp_col, exp_row, exp_last}) begin
      bad++;
      $display("FAIL stall_resume: got %h required %h", {detail_frame, detail_valid, out_col, out_row, frame_last},
               {exp_frame, exp_valid, exp_col, exp_row, exp_last});
    end
  endtask

  task automatic test_ramp();
    logic [DW-1:0] o;
    int e;
    drive(1'b0, 1'b0, '0, '0);
    for (int idx = 0; idx < 200; idx++) begin
      o = {NL{8'(idx % 256)}};
      drive(1'b1, 1'b0, o, '0);
      if (idx >= LAT) begin
        e = ((idx - LAT) % 256) + 128;
        if (e > 255) e = 255;
        total++;
        if (detail_frame[7:0] !== 8'(e) || detail_frame[127:120] !== 8'(e) || detail_valid !== 1'b1) begin
          bad++;
          $display("FAIL ramp beat %0d: got %0d/%0d v=%0b required %0d", idx, detail_frame[7:0], detail_frame[127:120], detail_valid, e);
        end
      end
    end
  endtask

  task automatic test_two_frames();
    int acc;
    int rises;
    logic prev_last;
    logic st;
    drive(1'b0, 1'b1, rnd_beat(), rnd_beat());
    acc = 0; rises = 0; prev_last = 1'b0;
    while (acc < LAT + 2 * DIM * COLS) begin
      st = 1'($urandom_range(0, 1));
      drive(1'b1, st, rnd_beat(), rnd_beat());
      if (!st) acc++;
      total++;
      if ({detail_frame, detail_valid, out_col, out_row, frame_last} !== {exp_frame, exp_valid, exp_col, exp_row, exp_last}) begin
        bad++;
        $display("FAIL two_frames accepted %0d: got %h required %h", acc, {detail_frame, detail_valid, out_col, out_row, frame_last},
                 {exp_frame, exp_valid, exp_col, exp_row, exp_last});
      end
      if (frame_last && !prev_last) begin
        rises++;
        total++;
        if (out_row !== 9'd511 || out_col !== 5'd31) begin
          bad++;
          $display("FAIL frame_last position: got row=%0d col=%0d required row=511 col=31", out_row, out_col);
        end
      end
      prev_last = frame_last;
    end
    total++;
    if (rises !== 2) begin
      bad++;
      $display("FAIL frame_last count: got %0d required 2", rises);
    end
  endtask

  task automatic test_midframe_reset();
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < LAT + 200 * COLS + 8; i++) drive(1'b1, 1'b0, rnd_beat(), rnd_beat());
    total++;
    if (out_row !== 9'd200 || out_col !== 5'd7 || detail_valid !== 1'b1) begin
      bad++;
      $display("FAIL midframe position: got row=%0d col=%0d v=%0b required row=200 col=7 v=1", out_row, out_col, detail_valid);
    end
    drive(1'b0, 1'b1, rnd_beat(), rnd_beat());
    total++;
    if ({detail_frame, detail_valid, out_col, out_row, frame_last} !== 144'h0) begin
      bad++;
      $display("FAIL midframe reset: got %h required 0", {detail_frame, detail_valid, out_col, out_row, frame_last});
    end
    for (int n = 0; n < LAT; ) begin
      stall = 1'($urandom_range(0, 1));
      drive(1'b1, stall, rnd_beat(), rnd_beat());
      if (!stall) n++;
      total++;
      if (detail_valid !== 1'b0 || detail_frame !== '0) begin
        bad++;
        $display("FAIL rewarm beat %0d: got v=%0b frame=%h required v=0 frame=0", n, detail_valid, detail_frame);
      end
    end
    drive(1'b1, 1'b0, rnd_beat(), rnd_beat());
    total++;
    if ({detail_frame, detail_valid, out_col, out_row, frame_last} !== {exp_frame, 1'b1, 5'd0, 9'd0, 1'b0}) begin
      bad++;
      $display("FAIL restart: got %h required %h", {detail_frame, detail_valid, out_col, out_row, frame_last},
               {exp_frame, 1'b1, 5'd0, 9'd0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_clamp();
    test_stall_hold();
    test_ramp();
    test_two_frames();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/detail_extract.md
DETAIL_EXTRACT -- requirements
Module: detail_extract

Interface
REQ-001 Parameter PIXELS_PER_BEAT, default 16, 8-bit pixels packed per beat, lane k = bits [8k+7:8k].
REQ-002 Parameter IMAGE_DIM, default 512, square image side in pixels.
REQ-003 Parameter DATA_WIDTH, default 8*PIXELS_PER_BEAT, beat width.
REQ-004 Parameter LAT_BEATS, default IMAGE_DIM/PIXELS_PER_BEAT+1, accepted-beat delay aligning original to blurred stream.
REQ-005 Parameter OFFSET, default 128, offset-binary bias added to detail.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 aresetn  input  1  reset, synchronous, active-low.
REQ-008 stall  input  1  global pipeline hold, shared with the Gaussian stage; 1 = no beat accepted.
REQ-009 orig_frame  input  DATA_WIDTH  raw beat, same beat driven into the Gaussian stage input.
REQ-010 blur_frame  input  DATA_WIDTH  Gaussian stage output beat for the current cycle.
REQ-011 detail_frame  output  DATA_WIDTH  registered per-lane detail beat.
REQ-012 detail_valid  output  1  detail_frame holds a valid result.
REQ-013 out_col  output  clog2(IMAGE_DIM/PIXELS_PER_BEAT)  beat column of current detail_frame.
REQ-014 out_row  output  clog2(IMAGE_DIM)  row of current detail_frame.
REQ-015 frame_last  output  1  detail_frame is last beat of a frame.

Function
REQ-016 Accepted beat = cycle with aresetn=1 and stall=0; all state (pointers, counters, outputs) SHALL hold when stall=1.
REQ-017 Each accepted beat SHALL write orig_frame into a LAT_BEATS-deep circular delay line and read the entry written LAT_BEATS accepted beats earlier (orig_d).
REQ-018 Per lane, detail = clamp(orig_d - blur + OFFSET, 0, 255), computed in 10-bit signed arithmetic, no wrap.
REQ-019 detail_frame SHALL update one clock after the accepted beat (latency 1 accepted cycle from blur_frame).
REQ-020 Warm-up counter SHALL count accepted beats after reset; detail_valid = 0 until LAT_BEATS beats accepted, then 1 on every subsequent result, remaining 1 through stalls.
REQ-021 While detail_valid = 0, detail_frame SHALL be 0.
REQ-022 out_col/out_row SHALL advance only on valid results: out_col increments, wraps to 0 at IMAGE_DIM/PIXELS_PER_BEAT-1, out_row increments on out_col wrap, wraps to 0 after IMAGE_DIM-1.
REQ-023 frame_last = 1 exactly when detail_valid=1, out_col=max, out_row=IMAGE_DIM-1; one beat wide (held through stall).
REQ-024 Frames are back-to-back; warm-up occurs only after reset, never at frame boundaries.
REQ-025 Delay-line read and write of the same entry in one accepted cycle SHALL return the old (pre-write) data.
REQ-026 Stall asserted on the cycle warm-up completes SHALL defer detail_valid until the next accepted beat.

Reset
REQ-027 On aresetn=0 at a clock edge: detail_frame=0, detail_valid=0, out_col=0, out_row=0, frame_last=0, warm-up counter=0, delay pointers=0.
REQ-028 Delay-line memory contents SHALL NOT be reset; warm-up masks them.
REQ-029 Reset mid-frame SHALL discard all in-flight data; behaviour afterwards identical to power-up.
REQ-030 Reset SHALL take priority over stall.

Structure
REQ-031 Shared package holds pixel width (8), OFFSET, COUNTER_MAX = IMAGE_DIM/PIXELS_PER_BEAT and clamp width constants.
REQ-032 One sub-module, beat_delay: circular buffer, depth LAT_BEATS, width DATA_WIDTH, single enable, inferable as RAM.
REQ-033 Lane datapath SHALL be a generate loop over PIXELS_PER_BEAT identical lanes.

Verification
REQ-034 Constant image 100 on orig, blur forced 100 -> after LAT_BEATS accepted beats every lane = 128, detail_valid rises exactly at beat LAT_BEATS+1.
REQ-035 orig_d lane = 255, blur = 0 -> 255 (clamped); orig_d = 0, blur = 200 -> 0 (clamped); orig_d = 10, blur = 5 -> 133.
REQ-036 Random stall (50%) over two full 512x512 frames -> output sequence equals no-stall golden model, frame_last asserted exactly twice, at out_row=511, out_col=31.
REQ-037 Reset asserted at row 200 col 7, released -> detail_valid low for next 33 accepted beats (defaults), counters restart at 0.
REQ-038 Ramp orig (lane value = beat index mod 256), blur = 0 -> detail lane equals value from 33 accepted beats earlier + 128, clamped.
REQ-039 stall held high 100 cycles mid-frame -> all outputs bit-identical throughout.
